// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII frame transmitter.
// FCS-related constants are only consumed when GMII_TX_FCS_EN is defined.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_DISCARD,
    S_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE        = 8'h55;
  localparam logic [7:0]  SFD_BYTE             = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/gmii_frame_transmitter_crc32_byte.sv
// One-byte CRC-32 step (reflected, LSB first); state register lives in the parent.
// Built only when GMII_TX_FCS_EN is defined.
`ifdef GMII_TX_FCS_EN
module crc32_byte
  import gmii_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY_REFLECTED) : (w_c >> 1);
    end
    o_crc = w_c;
  end

endmodule
`endif

// File: rtl/gmii_frame_transmitter.sv
// Drains whole frames from an egress byte FIFO onto a GMII TX port.
// Define GMII_TX_FCS_EN to add minimum-size padding and a CRC-32 FCS.
module gmii_frame_transmitter
  import gmii_tx_pkg::*;
#(
  parameter int PREAMBLE_BYTES  = 7,
`ifdef GMII_TX_FCS_EN
  parameter int MIN_FRAME_BYTES = 60,
`endif
  parameter int IFG_BYTES       = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] fifo_read_data,
  output logic       fifo_read_enable,
  input  logic       fifo_is_empty,
  input  logic       frame_available,
  output logic [7:0] gmii_tx_d,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_busy,
  output logic       tx_frame_done,
  output logic       tx_underrun
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_rd_valid;
  logic [7:0]  r_tx_d;
  logic        r_tx_en;
  logic        r_tx_er;
  logic        r_done;
  logic        r_underrun;
  fifo_entry_t w_entry;
  logic        w_last;
  logic        w_start;
  logic        w_pop;

  assign w_entry = fifo_entry_t'(fifo_read_data);
  assign w_start = frame_available & ~fifo_is_empty;
  assign w_last  = r_rd_valid & w_entry.last;

`ifdef GMII_TX_FCS_EN
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME_BYTES);

  logic [10:0] r_bytes;
  logic [10:0] w_bytes_nxt;
  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;
  logic [7:0]  w_crc_in;

  assign w_bytes_nxt = (r_bytes == 11'h7FF) ? r_bytes : r_bytes + 11'd1;
  assign w_crc_in    = (r_state == S_PAD) ? 8'h00 : w_entry.data;

  crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_in),
    .o_crc  (w_crc_nxt)
  );
`endif

  // Pop whenever the entry just read was not the frame's last one.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_SFD:             w_pop = ~fifo_is_empty;
      S_DATA, S_DISCARD: w_pop = ~fifo_is_empty & ~w_last;
      default:           w_pop = 1'b0;
    endcase
  end

  assign fifo_read_enable = w_pop;
  assign tx_busy          = (r_state != S_IDLE);
  assign gmii_tx_d        = r_tx_d;
  assign gmii_tx_en       = r_tx_en;
  assign gmii_tx_er       = r_tx_er;
  assign tx_frame_done    = r_done;
  assign tx_underrun      = r_underrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_rd_valid <= 1'b0;
      r_tx_d     <= 8'h00;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
`ifdef GMII_TX_FCS_EN
      r_bytes    <= 11'd0;
      r_crc      <= CRC32_INIT;
`endif
    end else begin
      r_rd_valid <= w_pop;
      r_tx_er    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx_en <= 1'b0;
          r_tx_d  <= 8'h00;
          if (w_start) begin
            r_tx_en <= 1'b1;
            r_tx_d  <= PREAMBLE_BYTE;
            r_cnt   <= 8'd1;
            r_state <= S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          r_tx_en <= 1'b1;
          r_tx_d  <= PREAMBLE_BYTE;
          r_cnt   <= r_cnt + 8'd1;
          if (r_cnt == PRE_LAST) r_state <= S_SFD;
        end
        S_SFD: begin
          r_tx_en <= 1'b1;
          r_tx_d  <= SFD_BYTE;
          r_state <= S_DATA;
`ifdef GMII_TX_FCS_EN
          r_bytes <= 11'd0;
          r_crc   <= CRC32_INIT;
`endif
        end
        S_DATA: begin
          r_tx_en <= 1'b1;
          r_cnt   <= 8'd0;
          if (r_rd_valid) begin
            r_tx_d <= w_entry.data;
`ifdef GMII_TX_FCS_EN
            r_bytes <= w_bytes_nxt;
            r_crc   <= w_crc_nxt;
            if (w_entry.last)
              r_state <= (w_bytes_nxt < MIN_CNT) ? S_PAD : S_FCS;
`else
            if (w_entry.last) begin
              r_done  <= 1'b1;
              r_state <= S_IFG;
            end
`endif
          end else begin
            // Nothing was popped last cycle: the FIFO ran dry mid-frame.
            r_tx_d     <= 8'h00;
            r_tx_er    <= 1'b1;
            r_underrun <= 1'b1;
            r_state    <= S_DISCARD;
          end
        end
`ifdef GMII_TX_FCS_EN
        S_PAD: begin
          r_tx_en <= 1'b1;
          r_tx_d  <= 8'h00;
          r_bytes <= w_bytes_nxt;
          r_crc   <= w_crc_nxt;
          if (w_bytes_nxt >= MIN_CNT) r_state <= S_FCS;
        end
        S_FCS: begin
          r_tx_en <= 1'b1;
          r_tx_d  <= ~r_crc[7:0];
          r_crc   <= {8'h00, r_crc[31:8]};
          r_cnt   <= r_cnt + 8'd1;
          if (r_cnt == 8'd3) begin
            r_done  <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_IFG;
          end
        end
`endif
        S_DISCARD: begin
          r_tx_en <= 1'b0;
          r_tx_d  <= 8'h00;
          r_cnt   <= 8'd0;
          if (w_last) r_state <= S_IFG;
        end
        S_IFG: begin
          r_tx_en <= 1'b0;
          r_tx_d  <= 8'h00;
          r_cnt   <= r_cnt + 8'd1;
          if (r_cnt == IFG_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx_en <= 1'b0;
          r_tx_d  <= 8'h00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_frame_transmitter.sv
// Directed bench for gmii_frame_transmitter with a simple FIFO model.
// Extra FCS checks are compiled in when GMII_TX_FCS_EN is defined.
module tb_gmii_frame_transmitter;

`ifdef GMII_TX_FCS_EN
  localparam int F = 4;
  localparam bit FCSON = 1'b1;
`else
  localparam int F = 0;
  localparam bit FCSON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] fifo_read_data = 9'h000;
  logic       fifo_read_enable;
  logic       fifo_is_empty;
  logic       frame_available;
  logic [7:0] gmii_tx_d;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       tx_busy;
  logic       tx_frame_done;
  logic       tx_underrun;

  logic [8:0] mem [0:2047];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  logic [7:0] cap [0:2047];
  int ncap = 0, n_done = 0, n_er = 0, n_und = 0;
  int done_idx = 0, zrun = 0, last_gap = 0;
  int n_tests = 0, n_fail = 0;

  always #4 clock = ~clock;

  gmii_frame_transmitter dut (
    .clock            (clock),
    .reset            (reset),
    .fifo_read_data   (fifo_read_data),
    .fifo_read_enable (fifo_read_enable),
    .fifo_is_empty    (fifo_is_empty),
    .frame_available  (frame_available),
    .gmii_tx_d        (gmii_tx_d),
    .gmii_tx_en       (gmii_tx_en),
    .gmii_tx_er       (gmii_tx_er),
    .tx_busy          (tx_busy),
    .tx_frame_done    (tx_frame_done),
    .tx_underrun      (tx_underrun)
  );

  assign fifo_is_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (fifo_read_enable && (wr_ptr != rd_ptr)) begin
      fifo_read_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (gmii_tx_en) begin
        cap[ncap] <= gmii_tx_d;
        ncap <= ncap + 1;
        if (zrun > 0) last_gap <= zrun;
        zrun <= 0;
      end else begin
        zrun <= zrun + 1;
      end
      if (tx_frame_done) begin
        n_done <= n_done + 1;
        done_idx <= ncap + 1;
      end
      if (gmii_tx_er) n_er <= n_er + 1;
      if (tx_underrun) n_und <= n_und + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int n, input int base, input bit last_on);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = {last_on && (i == n - 1), 8'((base + i) & 255)};
      wr_ptr = wr_ptr + 1;
    end
  endtask

  function automatic int count_bad(input int off, input int n, input int base);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (cap[off + i] !== 8'((base + i) & 255)) bad++;
    return bad;
  endfunction

  function automatic int count_const(input int off, input int n,
                                     input logic [7:0] v);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (cap[off + i] !== v) bad++;
    return bad;
  endfunction

`ifdef GMII_TX_FCS_EN
  function automatic logic [31:0] crc_frame(input int n, input int base);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0]  b;
    int          tot = (n < 60) ? 60 : n;
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? 8'((base + i) & 255) : 8'h00;
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [31:0] fcs_at(input int o);
    return {cap[o + 3], cap[o + 2], cap[o + 1], cap[o]};
  endfunction
`endif

  int b, b2, d0, e0, u0;

  initial begin
    reset = 1'b1;
    frame_available = 1'b0;
    cyc(3);
    check("rst_tx_en", gmii_tx_en, 0);
    check("rst_tx_er", gmii_tx_er, 0);
    check("rst_tx_d", gmii_tx_d, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_frame_done, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_rd_en", fifo_read_enable, 0);
    reset = 1'b0;
    cyc(2);

    // 68-byte frame
    b = ncap; d0 = n_done; e0 = n_er; u0 = n_und;
    push_frame(68, 'hA0, 1'b1);
    frame_available = 1'b1;
    cyc(120);
    frame_available = 1'b0;
    check("f68_len", ncap - b, 76 + F);
    check("f68_preamble", count_const(b, 7, 8'h55), 0);
    check("f68_sfd", cap[b + 7], 8'hD5);
    check("f68_payload", count_bad(b + 8, 68, 'hA0), 0);
    check("f68_done_cnt", n_done - d0, 1);
    check("f68_done_pos", done_idx - b, 76 + F);
    check("f68_er", n_er - e0, 0);
    check("f68_underrun", n_und - u0, 0);
`ifdef GMII_TX_FCS_EN
    check("f68_fcs", fcs_at(b + 76), crc_frame(68, 'hA0));
`endif

    // single-byte frame
    b = ncap; d0 = n_done;
    push_frame(1, 'h3C, 1'b1);
    frame_available = 1'b1;
    cyc(100);
    frame_available = 1'b0;
    check("f1_len", ncap - b, FCSON ? 72 : 9);
    check("f1_byte", cap[b + 8], 8'h3C);
    check("f1_done_cnt", n_done - d0, 1);
`ifdef GMII_TX_FCS_EN
    check("f1_pad", count_const(b + 9, 59, 8'h00), 0);
    check("f1_fcs", fcs_at(b + 68), crc_frame(1, 'h3C));

    // 10-byte frame padded to 60
    b = ncap; d0 = n_done;
    push_frame(10, 'h10, 1'b1);
    frame_available = 1'b1;
    cyc(100);
    frame_available = 1'b0;
    check("f10_len", ncap - b, 72);
    check("f10_payload", count_bad(b + 8, 10, 'h10), 0);
    check("f10_pad", count_const(b + 18, 50, 8'h00), 0);
    check("f10_fcs", fcs_at(b + 68), crc_frame(10, 'h10));
    check("f10_done_cnt", n_done - d0, 1);
`endif

    // two back-to-back 64-byte frames
    b = ncap; d0 = n_done;
    push_frame(64, 'h00, 1'b1);
    push_frame(64, 'h40, 1'b1);
    frame_available = 1'b1;
    cyc(250);
    frame_available = 1'b0;
    check("b2b_len", ncap - b, 2 * (72 + F));
    check("b2b_gap", last_gap, 12);
    check("b2b_done_cnt", n_done - d0, 2);
    check("b2b_payload1", count_bad(b + 8, 64, 'h00), 0);
    check("b2b_preamble2", count_const(b + 72 + F, 7, 8'h55), 0);
    check("b2b_sfd2", cap[b + 72 + F + 7], 8'hD5);
    check("b2b_payload2", count_bad(b + 80 + F, 64, 'h40), 0);
`ifdef GMII_TX_FCS_EN
    check("b2b_fcs1", fcs_at(b + 72), crc_frame(64, 'h00));
    check("b2b_fcs2", fcs_at(b + 148), crc_frame(64, 'h40));
`endif

    // underrun after 20 bytes of a 100-byte frame
    b = ncap; d0 = n_done; e0 = n_er; u0 = n_und;
    push_frame(20, 'h20, 1'b0);
    frame_available = 1'b1;
    cyc(40);
    check("ur_er_cnt", n_er - e0, 1);
    check("ur_pulse_cnt", n_und - u0, 1);
    check("ur_len", ncap - b, 29);
    check("ur_payload", count_bad(b + 8, 20, 'h20), 0);
    push_frame(80, 'h34, 1'b1);
    cyc(110);
    frame_available = 1'b0;
    check("ur_len_after", ncap - b, 29);
    check("ur_no_done", n_done - d0, 0);
    check("ur_drained", fifo_is_empty, 1);
    check("ur_idle", tx_busy, 0);

    // reset while byte 30 of a 100-byte frame is on the wire
    b = ncap;
    push_frame(100, 'h50, 1'b1);
    frame_available = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (ncap - b >= 38) break;
      cyc(1);
    end
    check("rs_reached", ncap - b, 38);
    reset = 1'b1;
    #1;
    check("rs_tx_en", gmii_tx_en, 0);
    check("rs_tx_er", gmii_tx_er, 0);
    check("rs_rd_en", fifo_read_enable, 0);
    check("rs_busy", tx_busy, 0);
    cyc(1);
    reset = 1'b0;
    frame_available = 1'b0;
    b2 = ncap;
    cyc(20);
    check("rs_stay_idle", ncap - b2, 0);
    check("rs_fifo_kept", fifo_is_empty, 0);
    check("rs_busy_idle", tx_busy, 0);
    frame_available = 1'b1;
    cyc(1);
    check("rs_restart_en", gmii_tx_en, 1);
    check("rs_restart_d", gmii_tx_d, 8'h55);
    frame_available = 1'b0;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
